// File: rtl/update_points_pkg.sv
// Shared types and saturation helpers for the update_points integrator.
// The arithmetic helpers work on a wide signed type and clamp to a caller-given width.
package update_points_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Wide enough for any practical position/velocity/acceleration width plus shift headroom.
    localparam int CALC_W = 32;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t sat(input calc_t val, input int width);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

    // -(most negative) clamps to most positive through sat().
    function automatic calc_t neg_sat(input calc_t val, input int width);
        return sat(-val, width);
    endfunction

endpackage

// File: rtl/update_points_if.sv
// Frame control, point load and readback signals of the update_points block.
// The slave modport is the integrator side, the master modport is the driving side.
interface update_points_if #(
    parameter int NUM_POINTS        = 8,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8
);
    localparam int IDX_W = $clog2(NUM_POINTS);

    logic                                begin_in;
    logic signed [ACCELERATION_SIZE-1:0] acceleration_x_in;
    logic signed [ACCELERATION_SIZE-1:0] acceleration_y_in;
    logic signed [POSITION_SIZE-1:0]     x_min_in;
    logic signed [POSITION_SIZE-1:0]     x_max_in;
    logic signed [POSITION_SIZE-1:0]     y_min_in;
    logic signed [POSITION_SIZE-1:0]     y_max_in;
    logic                                wr_en_in;
    logic [IDX_W-1:0]                    wr_idx_in;
    logic signed [POSITION_SIZE-1:0]     wr_pos_x_in;
    logic signed [POSITION_SIZE-1:0]     wr_pos_y_in;
    logic signed [VELOCITY_SIZE-1:0]     wr_vel_x_in;
    logic signed [VELOCITY_SIZE-1:0]     wr_vel_y_in;
    logic [IDX_W-1:0]                    rd_idx_in;
    logic signed [POSITION_SIZE-1:0]     rd_pos_x_out;
    logic signed [POSITION_SIZE-1:0]     rd_pos_y_out;
    logic signed [VELOCITY_SIZE-1:0]     rd_vel_x_out;
    logic signed [VELOCITY_SIZE-1:0]     rd_vel_y_out;
    logic                                busy_out;
    logic                                result_out;
    logic [IDX_W:0]                      collision_count_out;

    modport slave (
        input  begin_in, acceleration_x_in, acceleration_y_in,
        input  x_min_in, x_max_in, y_min_in, y_max_in,
        input  wr_en_in, wr_idx_in, wr_pos_x_in, wr_pos_y_in, wr_vel_x_in, wr_vel_y_in,
        input  rd_idx_in,
        output rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out,
        output busy_out, result_out, collision_count_out
    );

    modport master (
        output begin_in, acceleration_x_in, acceleration_y_in,
        output x_min_in, x_max_in, y_min_in, y_max_in,
        output wr_en_in, wr_idx_in, wr_pos_x_in, wr_pos_y_in, wr_vel_x_in, wr_vel_y_in,
        output rd_idx_in,
        input  rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out,
        input  busy_out, result_out, collision_count_out
    );

endinterface

// File: rtl/update_points_integrator.sv
// One axis of the point datapath: semi-implicit Euler integrate (stage 1)
// and box collision with damped reflection (stage 2). Purely combinational.
module point_integrator
    import update_points_pkg::*;
#(
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int DT_SHIFT          = 0,
    parameter int DAMP_SHIFT        = 1
) (
    input  logic signed [POSITION_SIZE-1:0]     pos_i,
    input  logic signed [VELOCITY_SIZE-1:0]     vel_i,
    input  logic signed [ACCELERATION_SIZE-1:0] acc_i,
    output logic signed [POSITION_SIZE-1:0]     pos_int_o,
    output logic signed [VELOCITY_SIZE-1:0]     vel_int_o,

    input  logic signed [POSITION_SIZE-1:0]     pos_col_i,
    input  logic signed [VELOCITY_SIZE-1:0]     vel_col_i,
    input  logic signed [POSITION_SIZE-1:0]     min_i,
    input  logic signed [POSITION_SIZE-1:0]     max_i,
    output logic signed [POSITION_SIZE-1:0]     pos_o,
    output logic signed [VELOCITY_SIZE-1:0]     vel_o,
    output logic                                hit_o
);

    always_comb begin
        calc_t v_new;
        calc_t p_new;
        // Position advances with the already-updated velocity.
        v_new     = sat(calc_t'(vel_i) + (calc_t'(acc_i) <<< DT_SHIFT), VELOCITY_SIZE);
        p_new     = sat(calc_t'(pos_i) + (v_new <<< DT_SHIFT), POSITION_SIZE);
        vel_int_o = VELOCITY_SIZE'(v_new);
        pos_int_o = POSITION_SIZE'(p_new);
    end

    always_comb begin
        calc_t bounce_v;
        bounce_v = neg_sat(calc_t'(vel_col_i) - (calc_t'(vel_col_i) >>> DAMP_SHIFT),
                           VELOCITY_SIZE);
        pos_o = pos_col_i;
        vel_o = vel_col_i;
        hit_o = 1'b0;
        // Lower wall wins when the bounds are inverted.
        if (pos_col_i < min_i) begin
            pos_o = min_i;
            vel_o = VELOCITY_SIZE'(bounce_v);
            hit_o = 1'b1;
        end else if (pos_col_i > max_i) begin
            pos_o = max_i;
            vel_o = VELOCITY_SIZE'(bounce_v);
            hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/update_points.sv
// Multi-point integrator: register file of point states swept one point per
// cycle through a two-stage integrate/collide pipeline on each frame start.
module update_points
    import update_points_pkg::*;
#(
    parameter int NUM_POINTS        = 8,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int DT_SHIFT          = 0,
    parameter int DAMP_SHIFT        = 1
) (
    input logic          clk_in,
    input logic          rst_n_in,
    update_points_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    typedef logic signed [POSITION_SIZE-1:0]     pos_t;
    typedef logic signed [VELOCITY_SIZE-1:0]     vel_t;
    typedef logic signed [ACCELERATION_SIZE-1:0] acc_t;

    state_e state_q, state_d;

    pos_t pos_x_q [NUM_POINTS];
    pos_t pos_y_q [NUM_POINTS];
    vel_t vel_x_q [NUM_POINTS];
    vel_t vel_y_q [NUM_POINTS];

    logic [IDX_W-1:0] issue_idx_q;
    acc_t             acc_x_q, acc_y_q;
    pos_t             x_min_q, x_max_q, y_min_q, y_max_q;

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_idx_q;
    pos_t             s1_pos_x_q, s1_pos_y_q;
    vel_t             s1_vel_x_q, s1_vel_y_q;

    logic [CNT_W-1:0] coll_cnt_q, count_out_q;
    pos_t             rd_pos_x_q, rd_pos_y_q;
    vel_t             rd_vel_x_q, rd_vel_y_q;

    logic start, issue, busy, result;
    logic wr_accept, wb_hit;
    logic [CNT_W-1:0] coll_cnt_next;

    pos_t int_pos_x, int_pos_y, wb_pos_x, wb_pos_y;
    vel_t int_vel_x, int_vel_y, wb_vel_x, wb_vel_y;
    logic hit_x, hit_y;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        issue   = 1'b0;
        busy    = 1'b0;
        result  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.begin_in) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = 1'b1;
                if (issue_idx_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                result = 1'b1;
                // Back-to-back frames: a begin in the result cycle starts the next sweep.
                if (bus.begin_in) begin
                    state_d = RUN;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_accept     = bus.wr_en_in && (state_q == IDLE);
    assign wb_hit        = s1_valid_q && (hit_x || hit_y);
    assign coll_cnt_next = coll_cnt_q + CNT_W'(wb_hit);

    point_integrator #(
        .POSITION_SIZE(POSITION_SIZE), .VELOCITY_SIZE(VELOCITY_SIZE),
        .ACCELERATION_SIZE(ACCELERATION_SIZE), .DT_SHIFT(DT_SHIFT), .DAMP_SHIFT(DAMP_SHIFT)
    ) u_axis_x (
        .pos_i(pos_x_q[issue_idx_q]), .vel_i(vel_x_q[issue_idx_q]), .acc_i(acc_x_q),
        .pos_int_o(int_pos_x), .vel_int_o(int_vel_x),
        .pos_col_i(s1_pos_x_q), .vel_col_i(s1_vel_x_q), .min_i(x_min_q), .max_i(x_max_q),
        .pos_o(wb_pos_x), .vel_o(wb_vel_x), .hit_o(hit_x)
    );

    point_integrator #(
        .POSITION_SIZE(POSITION_SIZE), .VELOCITY_SIZE(VELOCITY_SIZE),
        .ACCELERATION_SIZE(ACCELERATION_SIZE), .DT_SHIFT(DT_SHIFT), .DAMP_SHIFT(DAMP_SHIFT)
    ) u_axis_y (
        .pos_i(pos_y_q[issue_idx_q]), .vel_i(vel_y_q[issue_idx_q]), .acc_i(acc_y_q),
        .pos_int_o(int_pos_y), .vel_int_o(int_vel_y),
        .pos_col_i(s1_pos_y_q), .vel_col_i(s1_vel_y_q), .min_i(y_min_q), .max_i(y_max_q),
        .pos_o(wb_pos_y), .vel_o(wb_vel_y), .hit_o(hit_y)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            issue_idx_q <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_pos_x_q  <= '0;
            s1_pos_y_q  <= '0;
            s1_vel_x_q  <= '0;
            s1_vel_y_q  <= '0;
            coll_cnt_q  <= '0;
            count_out_q <= '0;
            rd_pos_x_q  <= '0;
            rd_pos_y_q  <= '0;
            rd_vel_x_q  <= '0;
            rd_vel_y_q  <= '0;
            // NOTE: the point array must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NUM_POINTS; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (start) begin
                issue_idx_q <= '0;
                acc_x_q     <= bus.acceleration_x_in;
                acc_y_q     <= bus.acceleration_y_in;
                x_min_q     <= bus.x_min_in;
                x_max_q     <= bus.x_max_in;
                y_min_q     <= bus.y_min_in;
                y_max_q     <= bus.y_max_in;
            end else if (issue) begin
                issue_idx_q <= issue_idx_q + 1'b1;
            end

            s1_valid_q <= issue;
            s1_idx_q   <= issue_idx_q;
            s1_pos_x_q <= int_pos_x;
            s1_pos_y_q <= int_pos_y;
            s1_vel_x_q <= int_vel_x;
            s1_vel_y_q <= int_vel_y;

            if (start) begin
                coll_cnt_q <= '0;
            end else begin
                coll_cnt_q <= coll_cnt_next;
            end
            if (state_q == DRAIN) count_out_q <= coll_cnt_next;

            // Loads only happen in IDLE and writeback only in RUN/DRAIN, so they never collide.
            if (wr_accept) begin
                pos_x_q[bus.wr_idx_in] <= bus.wr_pos_x_in;
                pos_y_q[bus.wr_idx_in] <= bus.wr_pos_y_in;
                vel_x_q[bus.wr_idx_in] <= bus.wr_vel_x_in;
                vel_y_q[bus.wr_idx_in] <= bus.wr_vel_y_in;
            end
            if (s1_valid_q) begin
                pos_x_q[s1_idx_q] <= wb_pos_x;
                pos_y_q[s1_idx_q] <= wb_pos_y;
                vel_x_q[s1_idx_q] <= wb_vel_x;
                vel_y_q[s1_idx_q] <= wb_vel_y;
            end

            rd_pos_x_q <= pos_x_q[bus.rd_idx_in];
            rd_pos_y_q <= pos_y_q[bus.rd_idx_in];
            rd_vel_x_q <= vel_x_q[bus.rd_idx_in];
            rd_vel_y_q <= vel_y_q[bus.rd_idx_in];
        end
    end

    assign bus.busy_out            = busy;
    assign bus.result_out          = result;
    assign bus.collision_count_out = count_out_q;
    assign bus.rd_pos_x_out        = rd_pos_x_q;
    assign bus.rd_pos_y_out        = rd_pos_y_q;
    assign bus.rd_vel_x_out        = rd_vel_x_q;
    assign bus.rd_vel_y_out        = rd_vel_y_q;

endmodule
